// File: rtl/spi_master_lbus.sv
// rtl/spi_master_lbus.sv - SPI master for local-bus bursts over the bridge (option: SPI_MASTER_LBUS_LATE_SAMPLE_EN)
module spi_master_lbus #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        rw,
    input  logic [15:0] addr,
    input  logic [7:0]  num_bytes,
    input  logic [7:0]  wdata,
    output logic        wdata_ack,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        done,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        reset_spi
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, TRAIL, HOLD, RELEASE} state_t;
    state_t state, state_nxt;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] REL_LAST  = 9'(2 * CLK_DIV - 1);

    logic [8:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [8:0]  bytes_left;
    logic        in_data;
    logic        rw_q;
    logic [7:0]  wdata_q;
    logic [23:0] sh;
    logic [6:0]  rx_sh;
    logic        half_end, seg_end, frame_end, sample;

    assign half_end  = (state == RELEASE) ? (div_cnt == REL_LAST) : (div_cnt == HALF_LAST);
    assign seg_end   = (bit_cnt == (in_data ? 5'd7 : 5'd23));
    // bit_cnt steps past 7 only on the fall of the final data bit
    assign frame_end = in_data && (bit_cnt == 5'd8);
    assign mosi      = sh[23];

`ifdef SPI_MASTER_LBUS_LATE_SAMPLE_EN
    assign sample = (state == SHIFT) && half_end && sclk && in_data && rw_q;
`else
    assign sample = (state == SHIFT) && half_end && !sclk && !frame_end && in_data && rw_q;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SETUP;
            SETUP:   if (half_end) state_nxt = SHIFT;
            SHIFT:   if (half_end && !sclk && frame_end) state_nxt = rw_q ? HOLD : TRAIL;
            TRAIL:   if (half_end && !sclk) state_nxt = HOLD;
            HOLD:    if (half_end) state_nxt = RELEASE;
            RELEASE: if (half_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            div_cnt     <= 9'd0;
            bit_cnt     <= 5'd0;
            bytes_left  <= 9'd0;
            in_data     <= 1'b0;
            rw_q        <= 1'b0;
            wdata_q     <= 8'h00;
            sh          <= 24'h0;
            rx_sh       <= 7'h0;
            rdata       <= 8'h00;
            rdata_valid <= 1'b0;
            wdata_ack   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            sclk        <= 1'b0;
            reset_spi   <= 1'b1;
        end else begin
            state       <= state_nxt;
            done        <= 1'b0;
            wdata_ack   <= 1'b0;
            rdata_valid <= 1'b0;
            div_cnt     <= (state != IDLE && !half_end) ? div_cnt + 9'd1 : 9'd0;
            if (wdata_ack) wdata_q <= wdata;
            if (sample) begin
                rx_sh <= {rx_sh[5:0], miso};
                if (bit_cnt == 5'd7) begin
                    rdata       <= {rx_sh, miso};
                    rdata_valid <= 1'b1;
                end
            end
            case (state)
                IDLE: if (start) begin
                    rw_q       <= rw;
                    wdata_q    <= wdata;
                    bytes_left <= (num_bytes == 8'd0) ? 9'd256 : {1'b0, num_bytes};
                    sh         <= {(rw ? 8'h02 : 8'h01), addr};
                    bit_cnt    <= 5'd0;
                    in_data    <= 1'b0;
                    busy       <= 1'b1;
                    reset_spi  <= 1'b0;
                end
                SETUP: if (half_end) sclk <= 1'b1;
                SHIFT: if (half_end) begin
                    if (sclk) begin
                        sclk <= 1'b0;
                        if (seg_end && bytes_left != 9'd0) begin
                            sh         <= {(rw_q ? 8'h00 : wdata_q), 16'h0000};
                            bytes_left <= bytes_left - 9'd1;
                            bit_cnt    <= 5'd0;
                            in_data    <= 1'b1;
                            wdata_ack  <= !rw_q && (bytes_left != 9'd1);
                        end else begin
                            sh      <= {sh[22:0], 1'b0};
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end else if (!frame_end || !rw_q) begin
                        // a write leaves SHIFT with the rising edge of the trailing pulse
                        sclk <= 1'b1;
                    end
                end
                TRAIL:   if (half_end && sclk) sclk <= 1'b0;
                HOLD:    if (half_end) reset_spi <= 1'b1;
                RELEASE: if (half_end) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_lbus.sv
// tb/tb_spi_master_lbus.sv - directed bench for spi_master_lbus against a bridge model
`timescale 1ns/1ps
module tb_spi_master_lbus;
    localparam int CD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = 16'h0;
    logic [7:0]  num_bytes = 8'h0;
    logic [7:0]  wdata = 8'h0;
    logic        wdata_ack, rdata_valid, busy, done, sclk, mosi, reset_spi;
    logic [7:0]  rdata;
    logic        miso = 1'b0;

    spi_master_lbus #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .rw(rw), .addr(addr),
        .num_bytes(num_bytes), .wdata(wdata), .wdata_ack(wdata_ack), .rdata(rdata),
        .rdata_valid(rdata_valid), .busy(busy), .done(done), .sclk(sclk), .mosi(mosi),
        .miso(miso), .reset_spi(reset_spi)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    // bridge model state
    int          rcnt = 0;
    int          tot_rises = 0;
    logic        s_prev = 1'b0, s_rd = 1'b0, s_wr = 1'b0, miso_raw = 1'b0;
    logic [23:0] s_sh = 24'h0;
    logic [31:0] frame32 = 32'h0;
    logic [15:0] s_addr = 16'h0;
    logic [7:0]  rd_base = 8'h00;
    logic [7:0]  byte_v;
    logic [15:0] pipe = 16'h0;
    int          dly = 0;
    bit          mosi_hi_data = 1'b0;
    logic [15:0] wlog_a[$];
    logic [7:0]  wlog_d[$];

    logic [7:0]  wq[$];
    logic [7:0]  rv_q[$];
    int          t_rise, t_done, done_cnt, ack_cnt;

    task automatic bridge_step();
        if (reset_spi) begin
            rcnt = 0; miso_raw = 1'b0; s_prev = 1'b0; s_rd = 1'b0; s_wr = 1'b0;
        end else begin
            if (sclk && !s_prev) begin
                tot_rises++;
                if (rcnt < 32) frame32 = {frame32[30:0], mosi};
                if (s_rd && rcnt >= 24 && mosi) mosi_hi_data = 1'b1;
                s_sh = {s_sh[22:0], mosi};
                rcnt++;
                if (rcnt == 24) begin
                    s_rd   = (s_sh[23:16] == 8'h02);
                    s_wr   = (s_sh[23:16] == 8'h01);
                    s_addr = s_sh[15:0];
                end else if (rcnt > 24 && ((rcnt - 24) % 8) == 0 && s_wr) begin
                    wlog_a.push_back(s_addr);
                    wlog_d.push_back(s_sh[7:0]);
                    s_addr = s_addr + 16'd1;
                end
            end
            if (!sclk && s_prev && s_rd && rcnt >= 24) begin
                byte_v   = rd_base + 8'((rcnt - 24) / 8);
                miso_raw = byte_v[7 - ((rcnt - 24) % 8)];
            end
            s_prev = sclk;
        end
        pipe = {pipe[14:0], miso_raw};
        miso = pipe[dly];
    endtask

    initial forever begin
        @(negedge clk);
        bridge_step();
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic r, input logic [15:0] a, input logic [7:0] n,
                           input int poke_at, input int abort_rise);
        int t0;
        int widx;
        wlog_a.delete(); wlog_d.delete(); rv_q.delete();
        tot_rises = 0; mosi_hi_data = 1'b0; frame32 = 32'h0;
        rw = r; addr = a; num_bytes = n;
        wdata = (wq.size() > 0) ? wq[0] : 8'h00;
        widx = 1;
        t_rise = -1; t_done = -1; done_cnt = 0; ack_cnt = 0;
        start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            start = (i == poke_at) ? 1'b1 : 1'b0;
            if (sclk && t_rise < 0) t_rise = cyc - t0;
            if (wdata_ack) begin
                ack_cnt++;
                if (widx < wq.size()) wdata = wq[widx];
                widx++;
            end
            if (rdata_valid) rv_q.push_back(rdata);
            if (done) begin
                done_cnt++;
                if (t_done < 0) t_done = cyc - t0;
            end
            if (abort_rise > 0 && tot_rises >= abort_rise) begin
                reset_n = 1'b0;
                break;
            end
            if (t_done >= 0 && (cyc - t0) > t_done + 20) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int bad;
        repeat (3) @(negedge clk);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_reset_spi", reset_spi, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wdata_ack", wdata_ack, 1'b0);
        chk("rst_rdata_valid", rdata_valid, 1'b0);
        chk("rst_rdata", rdata, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        // single-byte write
        wq = '{8'hA5};
        run_txn(1'b0, 16'h1234, 8'd1, -1, 0);
        chk("w1_frame", frame32, 32'h011234A5);
        chk("w1_rises", tot_rises, 33);
        chk("w1_nlog", wlog_a.size(), 1);
        chk("w1_addr", wlog_a[0], 16'h1234);
        chk("w1_data", wlog_d[0], 8'hA5);
        chk("w1_reset_spi", reset_spi, 1'b1);
        chk("w1_done_cnt", done_cnt, 1);
        chk("w1_first_rise", t_rise, 3);
        chk("w1_length", t_done, 141);
        chk("w1_acks", ack_cnt, 0);

        // 3-byte write across address wrap
        wq = '{8'hAA, 8'hBB, 8'hCC};
        run_txn(1'b0, 16'hFFFF, 8'd3, -1, 0);
        chk("w3_acks", ack_cnt, 2);
        chk("w3_nlog", wlog_a.size(), 3);
        chk("w3_a0", wlog_a[0], 16'hFFFF);
        chk("w3_d0", wlog_d[0], 8'hAA);
        chk("w3_a1", wlog_a[1], 16'h0000);
        chk("w3_d1", wlog_d[1], 8'hBB);
        chk("w3_a2", wlog_a[2], 16'h0001);
        chk("w3_d2", wlog_d[2], 8'hCC);
        chk("w3_length", t_done, 205);

        // 3-byte read
        wq = {};
        rd_base = 8'h10;
        run_txn(1'b1, 16'h00FF, 8'd3, -1, 0);
        chk("r3_hdr", frame32[31:8], 24'h0200FF);
        chk("r3_nvalid", rv_q.size(), 3);
        chk("r3_d0", rv_q[0], 8'h10);
        chk("r3_d1", rv_q[1], 8'h11);
        chk("r3_d2", rv_q[2], 8'h12);
        chk("r3_mosi_zero", mosi_hi_data, 1'b0);
        chk("r3_length", t_done, 201);
        chk("r3_acks", ack_cnt, 0);

        // start pulsed while busy is ignored
        rd_base = 8'h77;
        run_txn(1'b1, 16'h0100, 8'd1, 10, 0);
        chk("busy_start_done_cnt", done_cnt, 1);
        chk("busy_start_length", t_done, 137);
        chk("busy_start_busy_after", busy, 1'b0);
        chk("busy_start_data", rv_q[0], 8'h77);

        // num_bytes=0 means 256
        rd_base = 8'h00;
        run_txn(1'b1, 16'h4000, 8'd0, -1, 0);
        chk("r256_nvalid", rv_q.size(), 256);
        bad = 0;
        for (int i = 0; i < rv_q.size(); i++) if (rv_q[i] !== 8'(i)) bad++;
        chk("r256_bad_bytes", bad, 0);
        chk("r256_length", t_done, 8297);

        // reset mid-transfer
        run_txn(1'b1, 16'h2222, 8'd2, -1, 13);
        @(negedge clk);
        chk("abort_done_cnt", done_cnt, 0);
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_mosi", mosi, 1'b0);
        chk("abort_reset_spi", reset_spi, 1'b1);
        chk("abort_busy", busy, 1'b0);
        reset_n = 1'b1;
        rd_base = 8'h5A;
        run_txn(1'b1, 16'h3333, 8'd1, -1, 0);
        chk("post_abort_nvalid", rv_q.size(), 1);
        chk("post_abort_data", rv_q[0], 8'h5A);
        chk("post_abort_done_cnt", done_cnt, 1);

        // MISO arriving late: correct only with late sampling
        dly = CD;
        rd_base = 8'hC3;
        run_txn(1'b1, 16'h0042, 8'd1, -1, 0);
        chk("late_nvalid", rv_q.size(), 1);
`ifdef SPI_MASTER_LBUS_LATE_SAMPLE_EN
        chk("late_data", rv_q[0], 8'hC3);
`else
        chk("late_data", rv_q[0], 8'h61);
`endif
        dly = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
